// File: rtl/bmf_factor_decoder_if.sv
// Bus bundle for bmf_factor_decoder: basis config port, factor input stream,
// reconstructed-word output stream, transfer counter and FSM state for debug.
interface bmf_factor_decoder_if #(
  parameter int K  = 6,
  parameter int M  = 7,
  parameter int CW = 16
);
  localparam int RW = (K > 1) ? $clog2(K) : 1;

  logic          cfg_we;
  logic [RW-1:0] cfg_row;
  logic [M-1:0]  cfg_data;
  logic          cfg_commit;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_k;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_data;
  logic [CW-1:0] xfer_cnt;
  logic [1:0]    dbg_state;

  modport master (
    output cfg_we, cfg_row, cfg_data, cfg_commit, in_valid, in_k, out_ready,
    input  cfg_err, in_ready, out_valid, out_data, xfer_cnt, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_row, cfg_data, cfg_commit, in_valid, in_k, out_ready,
    output cfg_err, in_ready, out_valid, out_data, xfer_cnt, dbg_state
  );
endinterface

// File: rtl/bmf_factor_decoder.sv
// Streaming BMF decompressor: out = OR_i (k[i] ? H[i] : 0) with a double-buffered basis H.
// Define BMF_DEC_GF2_EN to reduce with XOR (GF(2) factorization) instead of OR.
module bmf_factor_decoder #(
  parameter int K  = 6,
  parameter int M  = 7,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bmf_factor_decoder_if.slave  bus
);
  localparam int RW = (K > 1) ? $clog2(K) : 1;

  // Handshakes: a beat moves on valid & ready in the same cycle; valid never
  // depends on ready, and a stalled output holds valid and data unchanged.
  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [M-1:0] r_shadow     [K];
  logic [M-1:0] r_active     [K];
  logic [M-1:0] w_shadow_nxt [K];
  logic [M-1:0] r_s1_terms   [K];
  logic         r_s1_valid;
  logic         r_s2_valid;
  logic [M-1:0] r_s2_data;
  logic [CW-1:0] r_xfer_cnt;
  logic         r_cfg_err;

  logic         w_adv;
  logic         w_in_ready;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_pipe_empty;
  logic         w_row_ok;
  logic         w_we_ok;
  logic         w_we_bad;
  logic         w_load_active;
  logic [M-1:0] w_reduced;

  assign w_adv        = !r_s2_valid || bus.out_ready;
  assign w_in_fire    = bus.in_valid && w_in_ready;
  assign w_out_fire   = r_s2_valid && bus.out_ready;
  assign w_pipe_empty = !r_s1_valid && !r_s2_valid;
  assign w_row_ok     = 32'(bus.cfg_row) < K;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_CFG;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_in_ready    = 1'b0;
    w_load_active = 1'b0;
    w_we_ok       = 1'b0;
    w_we_bad      = 1'b0;
    case (r_state)
      ST_CFG: begin
        w_we_ok  = bus.cfg_we && w_row_ok;
        w_we_bad = bus.cfg_we && !w_row_ok;
        if (bus.cfg_commit) begin
          w_load_active = 1'b1;
          w_state_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        w_in_ready = w_adv;
        w_we_ok    = bus.cfg_we && w_row_ok;
        w_we_bad   = bus.cfg_we && !w_row_ok;
        if (bus.cfg_commit) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Swap only once no word is in flight, so each word sees one basis.
        w_we_bad = bus.cfg_we;
        if (w_pipe_empty) begin
          w_load_active = 1'b1;
          w_state_nxt   = ST_RUN;
        end
      end
      default: w_state_nxt = ST_CFG;
    endcase
  end

  // Folding the same-cycle write in lets a commit carry it into the active bank.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (w_we_ok && (bus.cfg_row == RW'(i))) w_shadow_nxt[i] = bus.cfg_data;
    end
  end

  always_comb begin
    w_reduced = '0;
    for (int i = 0; i < K; i++) begin
`ifdef BMF_DEC_GF2_EN
      w_reduced = w_reduced ^ r_s1_terms[i];
`else
      w_reduced = w_reduced | r_s1_terms[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        r_shadow[i]   <= '0;
        r_active[i]   <= '0;
        r_s1_terms[i] <= '0;
      end
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_xfer_cnt <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      for (int i = 0; i < K; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_load_active) r_active[i] <= w_shadow_nxt[i];
      end
      r_cfg_err <= w_we_bad;
      if (w_adv) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) begin
          for (int i = 0; i < K; i++) r_s1_terms[i] <= {M{bus.in_k[i]}} & r_active[i];
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= w_reduced;
      end
      if (w_out_fire) r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.xfer_cnt  = r_xfer_cnt;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_bmf_factor_decoder.sv
// Directed bench for bmf_factor_decoder: reset, permutation basis, backpressure,
// commit under traffic, config errors and OR/XOR semiring.
module tb_bmf_factor_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  bmf_factor_decoder_if #(.K(6), .M(7), .CW(16)) bus ();

  bmf_factor_decoder #(.K(6), .M(7), .CW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [5:0] t3_k [8] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h03, 6'h3F};
  logic [6:0] t3_e [8] = '{7'h02, 7'h05, 7'h08, 7'h10, 7'h20, 7'h40, 7'h07, 7'h7F};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] row, input logic [6:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_row  = row;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) tick();
    chk(tag, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int sent, recv, stall, n_old;
    bus.cfg_we = 1'b0; bus.cfg_row = '0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    bus.in_valid = 1'b0; bus.in_k = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
    chk("rst_cfg_err",   32'(bus.cfg_err),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b0;
    tick();
    chk("cfg_state", 32'(bus.dbg_state), 32'd0);
    chk("cfg_in_ready", 32'(bus.in_ready), 32'd0);

    // T2: permutation basis, 2-cycle latency
    cfg_write(3'd0, 7'h02); cfg_write(3'd1, 7'h05); cfg_write(3'd2, 7'h08);
    cfg_write(3'd3, 7'h10); cfg_write(3'd4, 7'h20); cfg_write(3'd5, 7'h40);
    chk("t2_cfg_err", 32'(bus.cfg_err), 32'd0);
    commit_pulse();
    chk("t2_run_state", 32'(bus.dbg_state), 32'd1);
    chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_k = 6'b000011;
    tick();
    chk("t2_lat_e1", 32'(bus.out_valid), 32'd0);
    bus.in_k = 6'b100100;
    tick();
    chk("t2_w0_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_w0_data", 32'(bus.out_data), 32'h07);
    bus.in_k = 6'b000000;
    tick();
    chk("t2_w1_data", 32'(bus.out_data), 32'h48);
    bus.in_valid = 1'b0;
    tick();
    chk("t2_w2_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_w2_data", 32'(bus.out_data), 32'h00);
    tick();
    chk("t2_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_xfer_cnt", 32'(bus.xfer_cnt), 32'd3);

    // T3: 8 words, 5-cycle stall while word 3 is presented
    sent = 0; recv = 0; stall = 0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      bus.in_valid  = (sent < 8);
      bus.in_k      = (sent < 8) ? t3_k[sent] : 6'h00;
      bus.out_ready = !(bus.out_valid && recv == 3 && stall < 5);
      #1;
      if (bus.out_valid) begin
        chk("t3_data", 32'(bus.out_data), 32'(t3_e[recv]));
        if (!bus.out_ready) begin
          stall++;
          chk("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
        end else begin
          recv++;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("t3_recv", 32'(recv), 32'd8);
    chk("t3_sent", 32'(sent), 32'd8);
    chk("t3_stall", 32'(stall), 32'd5);
    chk("t3_xfer_cnt", 32'(bus.xfer_cnt), 32'd11);  // 3 from T2 plus 8

    // T4: rewrite row0 while streaming, commit, drain
    bus.in_valid = 1'b1; bus.in_k = 6'h01;
    bus.cfg_we = 1'b1; bus.cfg_row = 3'd0; bus.cfg_data = 7'h7F;
    tick();
    bus.cfg_we = 1'b0;
    commit_pulse();
    chk("t4_drain_state", 32'(bus.dbg_state), 32'd2);
    chk("t4_drain_in_ready", 32'(bus.in_ready), 32'd0);
    n_old = 0;
    for (int i = 0; i < 12 && bus.in_ready !== 1'b1; i++) begin
      if (bus.out_valid) begin
        chk("t4_old_basis", 32'(bus.out_data), 32'h02);
        n_old++;
      end
      tick();
    end
    chk("t4_old_words", 32'(n_old), 32'd2);
    chk("t4_run_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_k = 6'h02;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_new_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_new_row0", 32'(bus.out_data), 32'h7F);
    tick();
    chk("t4_row1", 32'(bus.out_data), 32'h05);
    tick();
    chk("t4_idle", 32'(bus.out_valid), 32'd0);

    // T5: bad row, write during DRAIN
    bus.cfg_we = 1'b1; bus.cfg_row = 3'd6; bus.cfg_data = 7'h7F;
    tick();
    bus.cfg_we = 1'b0;
    chk("t5_row_err", 32'(bus.cfg_err), 32'd1);
    tick();
    chk("t5_row_err_pulse", 32'(bus.cfg_err), 32'd0);
    commit_pulse();
    chk("t5_drain_state", 32'(bus.dbg_state), 32'd2);
    bus.cfg_we = 1'b1; bus.cfg_row = 3'd1; bus.cfg_data = 7'h7F;
    tick();
    bus.cfg_we = 1'b0;
    chk("t5_drain_err", 32'(bus.cfg_err), 32'd1);
    chk("t5_back_run", 32'(bus.dbg_state), 32'd1);
    tick();
    chk("t5_drain_err_pulse", 32'(bus.cfg_err), 32'd0);
    commit_pulse();
    wait_ready("t5_ready");
    bus.in_valid = 1'b1; bus.in_k = 6'h02;
    tick();
    bus.in_k = 6'h04;
    tick();
    bus.in_valid = 1'b0;
    chk("t5_row1_kept", 32'(bus.out_data), 32'h05);
    tick();
    chk("t5_row2_kept", 32'(bus.out_data), 32'h08);
    tick();

    // T6: semiring
    cfg_write(3'd0, 7'h03);
    cfg_write(3'd1, 7'h01);
    commit_pulse();
    wait_ready("t6_ready");
    bus.in_valid = 1'b1; bus.in_k = 6'b000011;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t6_valid", 32'(bus.out_valid), 32'd1);
`ifdef BMF_DEC_GF2_EN
    chk("t6_xor", 32'(bus.out_data), 32'h02);
`else
    chk("t6_or", 32'(bus.out_data), 32'h03);
`endif
    tick();

    // T1: reset with two words in flight
    bus.in_valid = 1'b1; bus.in_k = 6'h01;
    tick();
    bus.in_k = 6'h02;
    tick();
    rst = 1'b1;
    #1;
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_out_data", 32'(bus.out_data), 32'd0);
    chk("t1_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_state", 32'(bus.dbg_state), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t1_cfg_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_no_emit", 32'(bus.out_valid), 32'd0);
    commit_pulse();
    chk("t1_commit_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t1_zero_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_zero_basis", 32'(bus.out_data), 32'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
